// File: rtl/halfband_dec_pcm.sv
// 11-tap halfband decimate-by-2 filter, one shared multiplier, round + optional clamp (HALFBAND_DEC_SAT_EN).
// Latency: out_valid 5 cycles after the phase-1 accept; one output per two accepted inputs.
// Backpressure: in_ready is low while the MAC/OUT sequence runs; the output has no stall path.
module halfband_dec_pcm (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [23:0] in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [23:0] out,
    output logic               out_valid
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic               phase_q, phase_d;
    logic signed [23:0] d_q [11];
    logic signed [23:0] d_d [11];
    logic signed [45:0] acc_q, acc_d;
    logic signed [23:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic signed [24:0] pre_add;
    logic signed [17:0] coef;
    logic signed [42:0] prod;
    logic signed [45:0] acc_sum;
    logic signed [23:0] res;
    logic               accept;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q && !rst;

    // Symmetric taps share one multiply; odd taps other than the centre are zero.
    always_comb begin
        pre_add = '0;
        coef    = '0;
        case (k_q)
            2'd0: begin
                pre_add = 25'(d_q[0]) + 25'(d_q[10]);
                coef    = 18'sd2048;
            end
            2'd1: begin
                pre_add = 25'(d_q[2]) + 25'(d_q[8]);
                coef    = -18'sd10240;
            end
            2'd2: begin
                pre_add = 25'(d_q[4]) + 25'(d_q[6]);
                coef    = 18'sd40960;
            end
            default: begin
                pre_add = 25'(d_q[5]);
                coef    = 18'sd65536;
            end
        endcase
        prod    = 43'(pre_add) * 43'(coef);
        acc_sum = acc_q + 46'(prod);
    end

`ifdef HALFBAND_DEC_SAT_EN
    logic signed [28:0] r_full;

    always_comb begin
        r_full = 29'((acc_sum + 46'sd65536) >>> 17);
        if (r_full > 29'sd8388607) begin
            res = 24'h7FFFFF;
        end else if (r_full < -29'sd8388608) begin
            res = 24'h800000;
        end else begin
            res = r_full[23:0];
        end
    end
`else
    always_comb begin
        res = 24'((acc_sum + 46'sd65536) >>> 17);
    end
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        phase_d     = phase_q;
        d_d         = d_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    d_d[0] = in;
                    for (int i = 1; i < 11; i++) begin
                        d_d[i] = d_q[i-1];
                    end
                    phase_d = !phase_q;
                    if (phase_q) begin
                        state_d = S_MAC;
                        k_d     = 2'd0;
                        acc_d   = '0;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d     = S_OUT;
                    out_d       = res;
                    out_valid_d = 1'b1;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            phase_q     <= 1'b0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            phase_q     <= phase_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
        end
    end
endmodule

// File: tb/tb_halfband_dec_pcm.sv
// Directed bench for halfband_dec_pcm: hand-computed vectors plus a direct-form reference model.
`define CHK(TAG, OBS, EXP) begin vec++; assert ((OBS) === (EXP)) else begin bad++; $error("FAIL %s obs=%0d exp=%0d", TAG, (OBS), (EXP)); end end

module tb_halfband_dec_pcm;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [23:0] in_dat = '0;
    logic               in_ready;
    logic signed [23:0] out_dat;
    logic               out_valid;

    int vec = 0;
    int bad = 0;

    halfband_dec_pcm dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_dat),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_dat),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model state
    int                 h [11] = '{2048, 0, -10240, 0, 40960, 65536, 40960, 0, -10240, 0, 2048};
    logic signed [23:0] hist [$];
    logic signed [23:0] exp_q [$];
    bit                 ph = 1'b0;
    int                 n_pulse = 0;
    logic signed [23:0] last_out = '0;
    logic               prev_ov = 1'b0;
    logic signed [23:0] e_val;

    function automatic logic signed [23:0] model_out();
        longint s = 0;
        longint r;
        logic signed [63:0] rv;
        for (int i = 0; i < 11; i++) begin
            if (i < hist.size()) s += longint'(h[i]) * longint'(hist[i]);
        end
        r = (s + 64'sd65536) >>> 17;
`ifdef HALFBAND_DEC_SAT_EN
        if (r > 64'sd8388607) r = 64'sd8388607;
        if (r < -64'sd8388608) r = -64'sd8388608;
`endif
        rv = r;
        return rv[23:0];
    endfunction

    function automatic void model_accept(input logic signed [23:0] x);
        hist.push_front(x);
        if (hist.size() > 11) void'(hist.pop_back());
        if (ph) exp_q.push_back(model_out());
        ph = ~ph;
    endfunction

    function automatic void model_clear();
        hist.delete();
        exp_q.delete();
        ph = 1'b0;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            `CHK("ov_gap", prev_ov, 1'b0)
            if (exp_q.size() == 0) begin
                vec++;
                bad++;
                $error("FAIL unexpected_pulse obs=%0d exp=none", out_dat);
            end else begin
                e_val = exp_q.pop_front();
                `CHK("model_out", out_dat, e_val)
            end
            n_pulse++;
            last_out = out_dat;
        end
        prev_ov = out_valid;
    end

    task automatic cyc(input logic v, input logic signed [23:0] x,
                       output logic acc, output logic rdy, output logic ov);
        in_valid = v;
        in_dat   = x;
        @(negedge clk);
        rdy = in_ready;
        ov  = out_valid;
        acc = v && in_ready && !rst;
        @(posedge clk);
        #1;
        if (acc) model_accept(x);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        `CHK("rst_in_ready", in_ready, 1'b0)
        `CHK("rst_out_valid", out_valid, 1'b0)
        @(posedge clk);
        #1;
        `CHK("rst_out", out_dat, 24'sd0)
        rst = 1'b0;
    endtask

    task automatic push(input logic signed [23:0] x);
        logic a, r, o;
        int t;
        a = 1'b0;
        t = 0;
        while (!a && t < 20) begin
            cyc(1'b1, x, a, r, o);
            t++;
        end
        if (!a) begin
            vec++;
            bad++;
            $error("FAIL push_timeout obs=%0d exp=1", a);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target);
        logic a, r, o;
        int t;
        t = 0;
        while (n_pulse < target && t < 30) begin
            cyc(1'b0, 24'sd0, a, r, o);
            t++;
        end
        `CHK("pulse_count", n_pulse, target)
    endtask

    initial begin
        int base;
        int ramp;
        int acc_cnt;
        int cyc_cnt;
        int imp_exp [6];
        logic signed [23:0] fs [12];
        logic rdy_exp [8];
        logic ov_exp [8];
        logic a, r, o;
        logic signed [23:0] xr;
        logic signed [23:0] big_exp;

        @(posedge clk);
        #1;

        // DC: twelve samples of 1000 -> six outputs, the last one exactly 1000
        do_reset();
        base = n_pulse;
        push(24'sd1000);
        `CHK("out_before_first", out_dat, 24'sd0)
        for (int i = 1; i < 12; i++) push(24'sd1000);
        wait_pulses(base + 6);
        `CHK("dc_gain", last_out, 24'sd1000)

        // Impulse at phase 1 walks through the even taps
        do_reset();
        base = n_pulse;
        push(24'sd0);
        push(24'sd131072);
        wait_pulses(base + 1);
        `CHK("imp_0", last_out, 24'sd2048)
        imp_exp = '{-10240, 40960, 40960, -10240, 2048, 0};
        for (int i = 0; i < 6; i++) begin
            push(24'sd0);
            push(24'sd0);
            wait_pulses(base + 2 + i);
            `CHK("imp_n", last_out, 24'(imp_exp[i]))
        end

        // Full-scale overflow pattern
        do_reset();
        base = n_pulse;
        fs = '{24'sd0, 24'h7FFFFF, 24'sd0, 24'h800000, 24'sd0, 24'h7FFFFF,
               24'h7FFFFF, 24'h7FFFFF, 24'sd0, 24'h800000, 24'sd0, 24'h7FFFFF};
        for (int i = 0; i < 12; i++) push(fs[i]);
        wait_pulses(base + 6);
`ifdef HALFBAND_DEC_SAT_EN
        big_exp = 24'h7FFFFF;
`else
        big_exp = -24'sd5767169;
`endif
        `CHK("full_scale", last_out, big_exp)

        // in_valid held high: ready/valid cycle pattern with a counting ramp
        do_reset();
        rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ov_exp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ramp = 1;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 24'(ramp), a, r, o);
            if (a) ramp++;
            `CHK("hold_rdy", r, rdy_exp[c])
            `CHK("hold_ov", o, ov_exp[c])
        end
        for (int c = 0; c < 60; c++) begin
            cyc(1'b1, 24'(ramp), a, r, o);
            if (a) ramp++;
        end
        base = n_pulse;
        wait_pulses(base + exp_q.size());
        `CHK("ramp_accepts", ramp - 1, 20)

        // Reset in the second MAC cycle aborts the output
        do_reset();
        base = n_pulse;
        push(24'sd500);
        push(24'sd500);
        cyc(1'b0, 24'sd0, a, r, o);
        rst = 1'b1;
        model_clear();
        cyc(1'b0, 24'sd0, a, r, o);
        `CHK("midrst_rdy", r, 1'b0)
        `CHK("midrst_ov", o, 1'b0)
        rst = 1'b0;
        for (int c = 0; c < 10; c++) cyc(1'b0, 24'sd0, a, r, o);
        `CHK("midrst_no_pulse", n_pulse, base)
        `CHK("midrst_out", out_dat, 24'sd0)
        push(24'sd500);
        push(24'sd500);
        wait_pulses(base + 1);
        `CHK("midrst_restart", last_out, 24'sd8)

        // Random traffic against the reference model
        do_reset();
        acc_cnt = 0;
        cyc_cnt = 0;
        while (acc_cnt < 10000 && cyc_cnt < 80000) begin
            case ($urandom_range(0, 7))
                0:       xr = 24'h7FFFFF;
                1:       xr = 24'h800000;
                default: xr = 24'($urandom());
            endcase
            cyc(1'($urandom_range(0, 1)), xr, a, r, o);
            if (a) acc_cnt++;
            cyc_cnt++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) cyc(1'b0, 24'sd0, a, r, o);
        `CHK("rand_accepts", acc_cnt, 10000)
        `CHK("rand_drained", exp_q.size(), 0)

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
